// File: rtl/fetch_unit_rv32i_pkg.sv
// fetch_unit_rv32i_pkg: shared types for the RV32I fetch unit (fetch entry, FSM states, instruction width)
package fetch_unit_rv32i_pkg;
  localparam int ILEN = 32;
  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } FetchEntry;
`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_e;
`else
  typedef enum logic [1:0] {IDLE, RUN} fetch_state_e;
`endif
endpackage

// File: rtl/fetch_unit_rv32i_fifo.sv
// fetch_fifo: 2-entry FIFO of FetchEntry with synchronous clear
// Ports: clk_i, rst_i (async, active-high), push_i/push_data_i, pop_i, clear_i, head_o (entry at head), count_o (occupancy 0..2)
module fetch_fifo import fetch_unit_rv32i_pkg::*; (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  FetchEntry  push_data_i,
  input  logic       pop_i,
  input  logic       clear_i,
  output FetchEntry  head_o,
  output logic [1:0] count_o
);
  FetchEntry mem_q [2];
  logic wr_q, rd_q, push, pop;
  logic [1:0] cnt_q;
  assign pop = pop_i && cnt_q != 2'd0;
  // a full FIFO can still take a push when the head leaves in the same cycle
  assign push = push_i && (cnt_q != 2'd2 || pop);
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      mem_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else if (clear_i) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/fetch_unit_rv32i.sv
// fetch_unit_rv32i: RV32I instruction fetch unit with credit-limited requests, 2-entry buffer and redirect flushing
// Ports: i_Clock, i_Reset (async, active-high); memory side o_MemAddr/o_MemReq/i_MemReady, i_MemRdValid/i_MemRdData;
// decode side o_Inst/o_InstPC/o_InstValid/i_InstReady; execute side i_Redirect/i_RedirectPC;
// o_Fault (misaligned redirect) exists only when FETCH_MISALIGN_CHECK_EN is defined.
module fetch_unit_rv32i import fetch_unit_rv32i_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  output logic [31:0] o_MemAddr,
  output logic        o_MemReq,
  input  logic        i_MemReady,
  input  logic        i_MemRdValid,
  input  logic [31:0] i_MemRdData,
  output logic [31:0] o_Inst,
  output logic [31:0] o_InstPC,
  output logic        o_InstValid,
  input  logic        i_InstReady,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        o_Fault
`endif
);
  fetch_state_e state_q;
  logic [31:0] pc_q, pc_d, redir_pc;
  logic [31:0] ifq_q [2];
  logic ifq_wr_q, ifq_rd_q, accept, push;
  logic [1:0] out_q, out_d, drop_q, drop_d, fifo_cnt;
  FetchEntry head, push_entry;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, bad_redir;
  assign bad_redir = |i_RedirectPC[1:0];
  assign redir_pc = i_RedirectPC;
  assign o_Fault = fault_q;
`else
  assign redir_pc = i_RedirectPC & 32'hFFFF_FFFC;
`endif
  assign o_MemAddr = pc_q;
  // credit: never more requests in flight than free buffer slots
  assign o_MemReq = state_q == RUN && !i_Redirect && ({1'b0, out_q} + {1'b0, fifo_cnt}) < 3'd2;
  assign accept = o_MemReq && i_MemReady;
  assign push = i_MemRdValid && !i_Redirect && drop_q == 2'd0;
  assign push_entry = '{pc: ifq_q[ifq_rd_q], inst: i_MemRdData};
  assign out_d = out_q + {1'b0, accept} - {1'b0, i_MemRdValid};
  // a redirect turns every still-unanswered request into one to discard
  assign drop_d = i_Redirect ? out_q - {1'b0, i_MemRdValid} : drop_q - {1'b0, i_MemRdValid && drop_q != 2'd0};
  assign pc_d = i_Redirect ? redir_pc : accept ? pc_q + 32'd4 : pc_q;
  assign o_InstValid = fifo_cnt != 2'd0;
  assign o_Inst = head.inst;
  assign o_InstPC = head.pc;
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      out_q <= 2'd0;
      drop_q <= 2'd0;
      ifq_q <= '{default: '0};
      ifq_wr_q <= 1'b0;
      ifq_rd_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      pc_q <= pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      // in-flight PCs retire with every response, kept or dropped, so they stay aligned with memory order
      if (accept) begin
        ifq_q[ifq_wr_q] <= pc_q;
        ifq_wr_q <= ~ifq_wr_q;
      end
      if (i_MemRdValid) ifq_rd_q <= ~ifq_rd_q;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (i_Redirect) begin
        state_q <= bad_redir ? HALT : RUN;
        fault_q <= bad_redir;
      end else if (state_q == IDLE) state_q <= RUN;
`else
      state_q <= RUN;
`endif
    end
  fetch_fifo u_fifo (
    .clk_i      (i_Clock),
    .rst_i      (i_Reset),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (o_InstValid && i_InstReady),
    .clear_i    (i_Redirect),
    .head_o     (head),
    .count_o    (fifo_cnt)
  );
endmodule

// File: tb/tb_fetch_unit_rv32i.sv
// tb_fetch_unit_rv32i: self-checking bench for fetch_unit_rv32i with an in-order memory model and scoreboard
module tb_fetch_unit_rv32i;
  import fetch_unit_rv32i_pkg::*;
  typedef struct {logic [31:0] addr; int due;} pend_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_ready = 1'b0, rd_valid = 1'b0, inst_ready = 1'b0, redirect = 1'b0;
  logic [31:0] rd_data = '0, redirect_pc = '0;
  logic [31:0] mem_addr, inst, inst_pc;
  logic mem_req, inst_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault;
`endif
  int checks = 0, errors = 0, cyc = 0, mem_lat = 1, first_acc = -1, npops = 0;
  pend_t mem_q[$];
  FetchEntry sb[$];
  logic [31:0] acc[$];
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  fetch_unit_rv32i dut (
    .i_Clock(clk), .i_Reset(rst),
    .o_MemAddr(mem_addr), .o_MemReq(mem_req), .i_MemReady(mem_ready),
    .i_MemRdValid(rd_valid), .i_MemRdData(rd_data),
    .o_Inst(inst), .o_InstPC(inst_pc), .o_InstValid(inst_valid), .i_InstReady(inst_ready),
    .i_Redirect(redirect), .i_RedirectPC(redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .o_Fault(fault)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // one clock cycle: drive inputs after the edge, let them settle, then observe and score
  task automatic step(input logic rdy, input logic irdy, input logic redir, input logic [31:0] rpc);
    FetchEntry e;
    @(posedge clk);
    #1;
    cyc++;
    mem_ready = rdy;
    inst_ready = irdy;
    redirect = redir;
    redirect_pc = rpc;
    rd_valid = 1'b0;
    rd_data = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rd_valid = 1'b1;
      rd_data = memf(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    #1;
    s_req = mem_req;
    s_addr = mem_addr;
    s_valid = inst_valid;
    s_pc = inst_pc;
    if (redir) sb.delete();
    else if (inst_valid && irdy) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pc=%h inst=%h, expected no instruction", inst_pc, inst);
      end else begin
        e = sb.pop_front();
        npops++;
        if (inst_pc !== e.pc || inst !== e.inst) begin
          errors++;
          $display("FAIL pop_data: got pc=%h inst=%h, expected pc=%h inst=%h", inst_pc, inst, e.pc, e.inst);
        end
      end
    end
    if (mem_req && rdy) begin
      if (first_acc < 0) first_acc = cyc;
      mem_q.push_back('{addr: mem_addr, due: cyc + mem_lat});
      sb.push_back('{pc: mem_addr, inst: memf(mem_addr)});
      acc.push_back(mem_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b0; rd_valid = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    rd_data = '0; redirect_pc = '0;
    mem_q.delete(); sb.delete(); acc.delete();
    cyc = 0; first_acc = -1; mem_lat = 1; npops = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: req=%b addr=%h valid=%b inst=%h pc=%h, expected 0 00000000 0 00000000 00000000",
               mem_req, mem_addr, inst_valid, inst, inst_pc);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b expected 0", mem_req); end
  endtask

  task automatic test_stream();
    test_reset();
    step(1, 1, 0, 0);
    checks++;
    if (first_acc !== 1 || s_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: accepted at cycle %0d addr %h, expected cycle 1 addr 00000000", first_acc, s_addr);
    end
    step(1, 1, 0, 0);
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: valid=%b expected 0", s_valid); end
    step(1, 1, 0, 0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
      errors++;
      $display("FAIL fill_latency: valid=%b pc=%h expected 1 00000000", s_valid, s_pc);
    end
    repeat (12) step(1, 1, 0, 0);
    checks++;
    if (acc.size() < 3 || acc[0] !== 32'h0 || acc[1] !== 32'h4 || acc[2] !== 32'h8) begin
      errors++;
      $display("FAIL addr_seq: got %0d addresses first %h %h %h, expected 0 4 8", acc.size(), acc[0], acc[1], acc[2]);
    end
    checks++;
    if (npops < 5) begin errors++; $display("FAIL stream_pops: got %0d pops, expected at least 5", npops); end
  endtask

  task automatic test_backpressure();
    test_reset();
    repeat (8) step(1, 0, 0, 0);
    checks++;
    if (acc.size() !== 2 || s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_hold: reqs=%0d req=%b valid=%b pc=%h, expected 2 0 1 00000000", acc.size(), s_req, s_valid, s_pc);
    end
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    checks++;
    if (s_pc !== 32'h4 || acc.size() !== 3 || acc[2] !== 32'h8) begin
      errors++;
      $display("FAIL bp_resume: pc=%h reqs=%0d last=%h, expected 00000004 3 00000008", s_pc, acc.size(), acc[acc.size()-1]);
    end
  endtask

  task automatic test_stall();
    test_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0);
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d req=%b addr=%h, expected 1 00000000", i, s_req, s_addr);
      end
    end
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    checks++;
    if (acc.size() !== 2 || acc[0] !== 32'h0 || acc[1] !== 32'h4) begin
      errors++;
      $display("FAIL stall_release: reqs=%0d first=%h, expected 2 00000000", acc.size(), acc[0]);
    end
  endtask

  task automatic test_redirect_drop();
    test_reset();
    mem_lat = 3;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h100);
    mem_lat = 1;
    checks++;
    if (s_req !== 1'b0 || acc.size() !== 2) begin
      errors++;
      $display("FAIL redirect_req_low: req=%b outstanding reqs=%0d, expected 0 2", s_req, acc.size());
    end
    for (int i = 0; i < 20 && s_valid !== 1'b1; i++) step(1, 1, 0, 0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h100 || cyc !== 7) begin
      errors++;
      $display("FAIL redirect_drop: valid=%b pc=%h cycle=%0d, expected 1 00000100 7", s_valid, s_pc, cyc);
    end
  endtask

  task automatic test_redirect_pop();
    test_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 32'h40);
    checks++;
    if (s_valid !== 1'b1 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL redirect_pop_setup: valid=%b resp=%b, expected 1 1", s_valid, rd_valid);
    end
    step(1, 1, 0, 0);
    checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h40) begin
      errors++;
      $display("FAIL redirect_pop_flush: valid=%b req=%b addr=%h, expected 0 1 00000040", s_valid, s_req, s_addr);
    end
    for (int i = 0; i < 20 && s_valid !== 1'b1; i++) step(1, 1, 0, 0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h40) begin
      errors++;
      $display("FAIL redirect_pop_first: valid=%b pc=%h, expected 1 00000040", s_valid, s_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic hit;
    test_reset();
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h300);
    step(1, 1, 1, 32'h400);
    step(1, 1, 0, 0);
    checks++;
    if (s_addr !== 32'h400) begin errors++; $display("FAIL b2b_pc: addr=%h expected 00000400", s_addr); end
    for (int i = 0; i < 20 && s_valid !== 1'b1; i++) step(1, 1, 0, 0);
    hit = 1'b0;
    foreach (acc[i]) if (acc[i] == 32'h300) hit = 1'b1;
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h400 || hit) begin
      errors++;
      $display("FAIL b2b_first: valid=%b pc=%h fetched_300=%b, expected 1 00000400 0", s_valid, s_pc, hit);
    end
  endtask

  task automatic test_wrap();
    int idx;
    test_reset();
    step(1, 1, 1, 32'hFFFF_FFF8);
    repeat (10) step(1, 1, 0, 0);
    idx = -1;
    foreach (acc[i]) if (acc[i] == 32'hFFFF_FFFC && idx < 0) idx = i;
    checks++;
    if (idx < 0 || idx + 1 >= acc.size() || acc[idx+1] !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: index of FFFFFFFC=%0d of %0d reqs, expected it followed by 00000000", idx, acc.size());
    end
  endtask

  task automatic test_async_reset();
    test_reset();
    repeat (4) step(1, 0, 0, 0);
    checks++;
    if (s_valid !== 1'b1) begin errors++; $display("FAIL async_setup: valid=%b expected 1", s_valid); end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || mem_addr !== 32'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b addr=%h req=%b, expected 0 00000000 0", inst_valid, mem_addr, mem_req);
    end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_fault();
    test_reset();
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h102);
    step(1, 1, 0, 0);
    checks++;
    if (fault !== 1'b1 || s_req !== 1'b0) begin
      errors++;
      $display("FAIL fault_set: fault=%b req=%b, expected 1 0", fault, s_req);
    end
    repeat (3) step(1, 1, 0, 0);
    checks++;
    if (fault !== 1'b1 || s_req !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_halt: fault=%b req=%b valid=%b, expected 1 0 0", fault, s_req, s_valid);
    end
    step(1, 1, 1, 32'h200);
    step(1, 1, 0, 0);
    checks++;
    if (fault !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h200) begin
      errors++;
      $display("FAIL fault_clear: fault=%b req=%b addr=%h, expected 0 1 00000200", fault, s_req, s_addr);
    end
    for (int i = 0; i < 20 && s_valid !== 1'b1; i++) step(1, 1, 0, 0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h200) begin
      errors++;
      $display("FAIL fault_resume: valid=%b pc=%h, expected 1 00000200", s_valid, s_pc);
    end
  endtask
`endif

  initial begin
    test_stream();
    test_backpressure();
    test_stall();
    test_redirect_drop();
    test_redirect_pop();
    test_back_to_back();
    test_wrap();
    test_async_reset();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_fault();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
